// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU arbiter: word width, op codes, FSM states.
package fpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/fpu_rr_pick.sv
// Two-way round-robin select: the pointer breaks ties, a lone requester always wins.
module fpu_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_owner,
  output logic o_valid
);

  // Owner is the pointer's requester only when both are asking.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_owner = 1'b0;
    if (i_req0 && i_req1) begin
      o_owner = i_ptr;
    end else if (i_req1) begin
      o_owner = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto one shared FPU: grant, issue, wait with
// timeout, then return the result (or an error) to the owning requester.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] a0,
  input  logic [WORD_W-1:0] b0,
  input  logic [WORD_W-1:0] a1,
  input  logic [WORD_W-1:0] b1,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err_o,
  output logic [WORD_W-1:0] res_o,
  output logic              fpu_start,
  output logic [WORD_W-1:0] fpu_a,
  output logic [WORD_W-1:0] fpu_b,
  output logic [1:0]        fpu_op,
  input  logic              fpu_ready,
  input  logic              fpu_error,
  input  logic [WORD_W-1:0] fpu_result
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e        r_state;
  logic              r_ptr;
  logic              r_owner;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_res;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  fpu_op_e           r_op;

  logic w_owner;
  logic w_valid;
  logic w_take;

  fpu_rr_pick u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_ptr   (r_ptr),
    .o_owner (w_owner),
    .o_valid (w_valid)
  );

  // A grant happens only in IDLE; gating with rst keeps gnt low while held in reset.
  assign w_take = rst && (r_state == IDLE) && w_valid;

  // Transaction FSM: owner capture, FPU handshake, timeout and pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_owner;
            r_a     <= w_owner ? a1 : a0;
            r_b     <= w_owner ? b1 : b0;
            r_op    <= fpu_op_e'(w_owner ? op1 : op0);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_err   <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Error outranks ready; an errored result never reaches res_o.
          if (fpu_error) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (fpu_ready) begin
            r_res   <= fpu_result;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_ptr   <= ~r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0      = w_take && !w_owner;
  assign gnt1      = w_take &&  w_owner;
  assign fpu_start = (r_state == ISSUE);
  assign done0     = (r_state == RESP) && !r_owner;
  assign done1     = (r_state == RESP) &&  r_owner;
  assign err_o     = (r_state == RESP) &&  r_err;
  assign res_o     = r_res;
  assign fpu_a     = r_a;
  assign fpu_b     = r_b;
  assign fpu_op    = r_op;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Testbench for fpu_arbiter: directed vector table plus multi-cycle sequences,
// with a scoreboard queue of expected completions.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic        gnt0, gnt1, done0, done1, err_o, fpu_start;
  logic [15:0] res_o, fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_ready, fpu_error;
  logic [15:0] fpu_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // mode: 0 ready, 1 error, 2 ready+error together, 3 silent (timeout)
  typedef struct {
    logic        who;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          mode;
    int          n;
    logic [15:0] result;
    logic        exp_err;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct {
    logic        who;
    logic        err;
    logic [15:0] res;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[7];

  fpu_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .op0        (op0),
    .op1        (op1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .err_o      (err_o),
    .res_o      (res_o),
    .fpu_start  (fpu_start),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_ready  (fpu_ready),
    .fpu_error  (fpu_error),
    .fpu_result (fpu_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done0 || done1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_owner", {30'd0, done1, done0}, e.who ? 32'd2 : 32'd1);
        chk("err_o", {31'd0, err_o}, {31'd0, e.err});
        chk("res_o", {16'd0, res_o}, {16'd0, e.res});
        chk("done_latency", cyc, e.done_cyc);
      end
    end
  end

  task automatic wait_gnt(output bit got, output logic who_g);
    got   = 1'b0;
    who_g = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got   = 1'b1;
        who_g = gnt1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic who, input logic err, input logic [15:0] res, input int mode, input int n);
    exp_t e;
    e.who      = who;
    e.err      = err;
    e.res      = res;
    e.done_cyc = cyc + 2 + ((mode == 3) ? TO : n);
    sbq.push_back(e);
  endtask

  // Called in the ISSUE cycle: checks the launch, plays the FPU, waits for done.
  task automatic serve(input int mode, input int n, input logic [15:0] result,
                       input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] eop);
    @(negedge clk);
    chk("fpu_start", {31'd0, fpu_start}, 32'd1);
    chk("fpu_a", {16'd0, fpu_a}, {16'd0, ea});
    chk("fpu_b", {16'd0, fpu_b}, {16'd0, eb});
    chk("fpu_op", {30'd0, fpu_op}, {30'd0, eop});
    if (mode != 3) begin
      for (int k = 1; k <= n; k++) begin
        @(posedge clk);
        #1;
        if (k == n) begin
          fpu_ready  = (mode != 1);
          fpu_error  = (mode != 0);
          fpu_result = result;
        end
      end
      @(negedge clk);
      chk("fpu_a_hold", {16'd0, fpu_a}, {16'd0, ea});
      @(posedge clk);
      #1;
      fpu_ready = 1'b0;
      fpu_error = 1'b0;
    end
    for (int k = 0; k < TO + 10 && sbq.size() != 0; k++) @(posedge clk);
    chk("done_seen", sbq.size(), 32'd0);
    if (sbq.size() != 0) sbq.delete();
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit   got;
    logic w;
    if (v.who) begin
      req1 = 1'b1; a1 = v.a; b1 = v.b; op1 = v.op;
    end else begin
      req0 = 1'b1; a0 = v.a; b0 = v.b; op0 = v.op;
    end
    wait_gnt(got, w);
    chk("grant_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("grant_owner", {31'd0, w}, {31'd0, v.who});
      push_exp(v.who, v.exp_err, v.exp_res, v.mode, v.n);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      serve(v.mode, v.n, v.result, v.a, v.b, v.op);
    end else begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctrl", {26'd0, gnt0, gnt1, done0, done1, err_o, fpu_start}, 32'd0);
    chk("rst_res", {16'd0, res_o}, 32'd0);
    chk("rst_fpu_a", {16'd0, fpu_a}, 32'd0);
    chk("rst_fpu_b", {16'd0, fpu_b}, 32'd0);
    chk("rst_fpu_op", {30'd0, fpu_op}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   got;
    logic w;
    vec_t rv;

    vecs[0] = '{1'b0, 16'h3C00, 16'h4000, 2'b00, 0, 3, 16'h4200, 1'b0, 16'h4200};
    vecs[1] = '{1'b1, 16'h4400, 16'h4200, 2'b10, 1, 2, 16'h7777, 1'b1, 16'h4200};
    vecs[2] = '{1'b0, 16'h4800, 16'h3C00, 2'b11, 3, 0, 16'h0000, 1'b1, 16'h4200};
    vecs[3] = '{1'b1, 16'h3C00, 16'h3C00, 2'b01, 2, 1, 16'h5555, 1'b1, 16'h4200};
    vecs[4] = '{1'b1, 16'h4000, 16'h4000, 2'b10, 0, 1, 16'h4600, 1'b0, 16'h4600};
    vecs[5] = '{1'b0, 16'h4200, 16'h4000, 2'b11, 0, 8, 16'h3800, 1'b0, 16'h3800};
    vecs[6] = '{1'b0, 16'h4000, 16'h3C00, 2'b01, 0, 2, 16'h0123, 1'b0, 16'h0123};

    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b0;
    a0 = 16'h1111; b0 = 16'h2222; op0 = 2'b00;
    a1 = 16'h3333; b1 = 16'h4444; op1 = 2'b11;
    fpu_ready = 1'b0; fpu_error = 1'b0; fpu_result = 16'h0;

    // Reset with a request pending: everything must stay low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Contention: both requesting continuously, grants alternate 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(got, w);
      chk("cont_grant_seen", {31'd0, got}, 32'd1);
      if (!got) break;
      chk("cont_owner", {31'd0, w}, i[31:0] & 32'd1);
      push_exp(w, 1'b0, 16'h1000 + 16'(i), 0, 2);
      @(posedge clk);
      #1;
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (w) serve(0, 2, 16'h1000 + 16'(i), 16'h3333, 16'h4444, 2'b11);
      else   serve(0, 2, 16'h1000 + 16'(i), 16'h1111, 16'h2222, 2'b00);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Strobes in IDLE must be ignored.
    fpu_ready = 1'b1; fpu_error = 1'b1; fpu_result = 16'hDEAD;
    @(posedge clk);
    #1;
    fpu_ready = 1'b0; fpu_error = 1'b0;
    @(negedge clk);
    chk("idle_strobe_ignored", {16'd0, res_o}, 32'h1003);
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of WAIT aborts with no done pulse.
    req0 = 1'b1; a0 = 16'h5000; b0 = 16'h5100; op0 = 2'b10;
    wait_gnt(got, w);
    chk("abort_grant_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req0 = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    req0 = 1'b0;
    rst  = 1'b1;

    // After reset, a lone req1 is granted.
    rv = '{1'b1, 16'h3E00, 16'h4100, 2'b00, 0, 3, 16'h4A00, 1'b0, 16'h4A00};
    run_vec(rv);

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
